// File: rtl/axi_ddr_resp_pkg.sv
// Shared definitions for the axi_ddr_resp AXI4 slave memory.
// Holds the default bus widths, AXI response/burst encodings, the FSM state
// type and a small helper that turns the write error flag into a BRESP code.
package axi_ddr_resp_pkg;

  // Default widths of the DDR-side AXI bus of ext_mem
  localparam int DDR_ADDR_W = 32;
  localparam int MIG_BUS_W  = 32;

  // AXI response and burst encodings
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_WRESP = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  function automatic logic [1:0] write_resp(input logic err);
    return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_ddr_resp_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port whose output holds its value whenever no read is issued.
// Ports:
//   clk    - clock
//   rd_en  - issue a read of addr; rdata updates on the next edge
//   wr_be  - per-byte write enables for a write at addr
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data
module axi_ddr_resp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents and read register are deliberately not reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_be[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_ddr_resp.sv
// AXI4 slave memory terminating the DDR-side bus of the L2 cache. Handles one
// INCR burst at a time out of an internal byte-enabled RAM; reads stream one
// beat per cycle. Upper address bits are ignored, so the RAM aliases.
// Ports:
//   clk, rst         - clock, asynchronous active-low reset
//   axi_aw*          - write address channel (size/burst/lock/cache/prot/qos ignored)
//   axi_w*           - write data channel
//   axi_b*           - write response channel
//   axi_ar*          - read address channel (same fields ignored)
//   axi_r*           - read data channel
module axi_ddr_resp
  import axi_ddr_resp_pkg::*;
#(
  parameter int ADDR_W     = DDR_ADDR_W,
  parameter int DATA_W     = MIG_BUS_W,
  parameter int MEM_ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                axi_awid,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [7:0]          axi_awlen,
  input  logic [2:0]          axi_awsize,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awlock,
  input  logic [3:0]          axi_awcache,
  input  logic [2:0]          axi_awprot,
  input  logic [3:0]          axi_awqos,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic                axi_bid,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic                axi_arid,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [7:0]          axi_arlen,
  input  logic [2:0]          axi_arsize,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arlock,
  input  logic [3:0]          axi_arcache,
  input  logic [2:0]          axi_arprot,
  input  logic [3:0]          axi_arqos,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic                axi_rid,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready
);

  localparam int OFF = $clog2(DATA_W / 8);

  state_t                  state, state_next;
  logic [MEM_ADDR_W-1:0]   idx;
  logic [7:0]              len;
  logic [7:0]              cnt;
  logic                    id;
  logic                    err;
  logic                    active;
  logic                    last_beat;
  logic                    ram_rd;
  logic [DATA_W/8-1:0]     ram_be;
  logic [MEM_ADDR_W-1:0]   ram_addr;
  logic [MEM_ADDR_W-1:0]   aw_idx;
  logic [MEM_ADDR_W-1:0]   ar_idx;
  logic                    unused_inputs;

  assign aw_idx    = axi_awaddr[MEM_ADDR_W+OFF-1:OFF];
  assign ar_idx    = axi_araddr[MEM_ADDR_W+OFF-1:OFF];
  assign last_beat = (cnt == len);

  assign axi_bid   = id;
  assign axi_rid   = id;
  assign axi_rresp = AXI_RESP_OKAY;

  // Burst attributes and out-of-range address bits carry no meaning here
  assign unused_inputs = ^{axi_awaddr, axi_awsize, axi_awburst, axi_awlock,
                           axi_awcache, axi_awprot, axi_awqos,
                           axi_araddr, axi_arsize, axi_arburst, axi_arlock,
                           axi_arcache, axi_arprot, axi_arqos};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Ready/valid outputs, RAM control and next state. Address readies are held
  // off until the first edge after reset via the active flag. A read of the
  // next word is only launched on an accepted non-last beat so rdata holds
  // under backpressure.
  always_comb begin
    state_next  = state;
    axi_awready = 1'b0;
    axi_arready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = AXI_RESP_OKAY;
    axi_rvalid  = 1'b0;
    axi_rlast   = 1'b0;
    ram_rd      = 1'b0;
    ram_be      = '0;
    ram_addr    = idx;
    case (state)
      ST_IDLE: begin
        if (active) begin
          axi_awready = 1'b1;
          axi_arready = ~axi_awvalid;
          if (axi_awvalid) begin
            state_next = ST_WDATA;
          end else if (axi_arvalid) begin
            state_next = ST_RDATA;
            ram_rd     = 1'b1;
            ram_addr   = ar_idx;
          end
        end
      end
      ST_WDATA: begin
        axi_wready = 1'b1;
        if (axi_wvalid) begin
          ram_be = axi_wstrb;
          if (last_beat) begin
            state_next = ST_WRESP;
          end
        end
      end
      ST_WRESP: begin
        axi_bvalid = 1'b1;
        axi_bresp  = write_resp(err);
        if (axi_bready) begin
          state_next = ST_IDLE;
        end
      end
      ST_RDATA: begin
        axi_rvalid = 1'b1;
        axi_rlast  = last_beat;
        if (axi_rready) begin
          if (last_beat) begin
            state_next = ST_IDLE;
          end else begin
            ram_rd   = 1'b1;
            ram_addr = idx + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Burst bookkeeping: index, length, beat count, id and the wlast error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      idx    <= '0;
      len    <= '0;
      cnt    <= '0;
      id     <= 1'b0;
      err    <= 1'b0;
    end else begin
      active <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (active && axi_awvalid) begin
            idx <= aw_idx;
            len <= axi_awlen;
            id  <= axi_awid;
            cnt <= '0;
            err <= 1'b0;
          end else if (active && axi_arvalid) begin
            idx <= ar_idx;
            len <= axi_arlen;
            id  <= axi_arid;
            cnt <= '0;
          end
        end
        ST_WDATA: begin
          if (axi_wvalid) begin
            err <= err | (axi_wlast != last_beat);
            cnt <= cnt + 8'd1;
            idx <= idx + 1'b1;
          end
        end
        ST_RDATA: begin
          if (axi_rready && !last_beat) begin
            cnt <= cnt + 8'd1;
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  axi_ddr_resp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rd_en (ram_rd),
    .wr_be (ram_be),
    .addr  (ram_addr),
    .wdata (axi_wdata),
    .rdata (axi_rdata)
  );

endmodule
